unsaved_cpu_debug_scan_master: RTL and testbench

//   JTAG-side initiator for the CPU debug slave's virtual-JTAG port. It turns one

---
 rtl/debug_scan_pkg.sv | 21 ++
 rtl/unsaved_cpu_debug_scan_master_if.sv | 37 +++
 rtl/unsaved_cpu_debug_scan_tckgen.sv | 56 +++++
 rtl/unsaved_cpu_debug_scan_master.sv | 134 +++++++++++++
 tb/tb_unsaved_cpu_debug_scan_master.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the CPU debug virtual-JTAG scan master.
package debug_scan_pkg;

  localparam int DEF_SR_WIDTH = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RSP
  } state_e;

endpackage

// File: rtl/unsaved_cpu_debug_scan_master_if.sv
// Command/response handshake plus the virtual-JTAG pins of the scan master.
interface unsaved_cpu_debug_scan_master_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic                busy;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic [IR_WIDTH-1:0] vji_ir_out;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;
  logic                vji_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, busy,
           vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, busy,
           vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );
endinterface

// File: rtl/unsaved_cpu_debug_scan_tckgen.sv
// tck divider: toggles every TCK_DIV clk cycles while run is high, parked low otherwise.
module unsaved_cpu_debug_scan_tckgen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);
  localparam int DIV_W = $clog2(TCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TCK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tck_q, tck_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // rise/fall pulses are asserted in the same cycle tck itself changes
  always_comb begin
    div_d  = div_q;
    tck_d  = tck_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!run) begin
      div_d = DIV_LOAD;
      tck_d = 1'b0;
    end else if (div_q == '0) begin
      div_d  = DIV_LOAD;
      tck_d  = ~tck_q;
      rise_d = ~tck_q;
      fall_d = tck_q;
    end else begin
      div_d = div_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q  <= DIV_LOAD;
      tck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tck_q  <= tck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign tck      = tck_q;
  assign tck_rise = rise_q;
  assign tck_fall = fall_q;
endmodule

// File: rtl/unsaved_cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator: one {IR, DR} command -> UIR, CDR, SDR x SR_WIDTH, UDR, RTI.
//   state | meaning
//   IDLE  | waiting for a command, tck parked low, rti strobe high
//   UIR   | one tck period, slave IR status captured on the rise
//   CDR   | one tck period, slave captures its DR
//   SDR   | SR_WIDTH periods, tdi driven LSB first, tdo shifted in on each rise
//   UDR   | one tck period, slave updates from its DR
//   RTI   | RTI_CYCLES periods so the slave's sysclk side finishes its UDR sync
//   RSP   | response held until rsp_ready, tck parked low
module unsaved_cpu_debug_scan_master
  import debug_scan_pkg::*;
#(
  parameter int SR_WIDTH   = DEF_SR_WIDTH,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 4,
  parameter int RTI_CYCLES = 4
) (
  input logic clk,
  input logic reset_n,
  unsaved_cpu_debug_scan_master_if.master bus
);
  localparam int CNT_W = $clog2(SR_WIDTH + 1);

  state_e              state_q, state_d;
  logic [SR_WIDTH-1:0] shift_q, shift_d;
  logic [SR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tdi_q, tdi_d;
  logic                rdy_q, rdy_d;
  logic                tck, tck_rise, tck_fall;

  unsaved_cpu_debug_scan_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      ((state_q != IDLE) && (state_q != RSP)),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    rsp_dr_d = rsp_dr_q;
    ir_in_d  = ir_in_q;
    rsp_ir_d = rsp_ir_q;
    cnt_d    = cnt_q;
    tdi_d    = tdi_q;
    case (state_q)
      IDLE: if (bus.cmd_valid && rdy_q) begin
        ir_in_d = bus.cmd_ir;
        shift_d = bus.cmd_dr;
        cnt_d   = '0;
        state_d = UIR;
      end
      UIR: begin
        if (tck_rise) rsp_ir_d = bus.vji_ir_out;
        if (tck_fall) state_d = CDR;
      end
      CDR: if (tck_fall) begin
        state_d = SDR;
        tdi_d   = shift_q[0];
      end
      SDR: begin
        if (tck_rise) begin
          shift_d = {bus.vji_tdo, shift_q[SR_WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end
        // after each rise shift_q[0] already holds the next bit to present
        if (tck_fall) begin
          if (cnt_q == CNT_W'(SR_WIDTH)) begin
            state_d = UDR;
            tdi_d   = 1'b0;
          end else begin
            tdi_d = shift_q[0];
          end
        end
      end
      UDR: if (tck_fall) begin
        state_d = RTI;
        cnt_d   = CNT_W'(RTI_CYCLES - 1);
      end
      RTI: if (tck_fall) begin
        if (cnt_q == '0) begin
          state_d  = RSP;
          rsp_dr_d = shift_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RSP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      rsp_dr_q <= '0;
      ir_in_q  <= IR_WIDTH'(IR_OCIMEM);
      rsp_ir_q <= '0;
      cnt_q    <= '0;
      tdi_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      rsp_dr_q <= rsp_dr_d;
      ir_in_q  <= ir_in_d;
      rsp_ir_q <= rsp_ir_d;
      cnt_q    <= cnt_d;
      tdi_q    <= tdi_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.cmd_ready  = rdy_q;
  assign bus.rsp_valid  = (state_q == RSP);
  assign bus.rsp_dr     = rsp_dr_q;
  assign bus.rsp_ir_out = rsp_ir_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.vji_tck    = tck;
  assign bus.vji_tdi    = tdi_q;
  assign bus.vji_ir_in  = ir_in_q;
  assign bus.vji_uir    = (state_q == UIR);
  assign bus.vji_cdr    = (state_q == CDR);
  assign bus.vji_sdr    = (state_q == SDR);
  assign bus.vji_udr    = (state_q == UDR);
  assign bus.vji_rti    = (state_q == RTI) || (state_q == IDLE) || (state_q == RSP);
endmodule

// File: tb/tb_unsaved_cpu_debug_scan_master.sv
// Directed bench for the debug scan master with a loopback virtual-JTAG slave model.
module tb_unsaved_cpu_debug_scan_master;
  import debug_scan_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  unsaved_cpu_debug_scan_master_if #(.SR_WIDTH(38), .IR_WIDTH(2)) bus ();

  unsaved_cpu_debug_scan_master #(
    .SR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(4), .RTI_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave model: tdo returns the tdi seen one sdr rise earlier; first_tdo seeds the first bit
  logic        first_tdo = 1'b1;
  logic        held = 1'b0;
  logic        tck_prev = 1'b0;
  int          sdr_rises = 0;
  int          udr_rises = 0;
  int          onehot_err = 0;
  int          udr_q[$];
  logic [37:0] rsp_q[$];

  always @(negedge clk) begin
    if (!$onehot({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}))
      onehot_err <= onehot_err + 1;
    if (bus.cmd_valid && bus.cmd_ready) begin
      held      <= first_tdo;
      sdr_rises <= 0;
      udr_rises <= 0;
    end
    if (bus.vji_tck && !tck_prev) begin
      if (bus.vji_sdr) begin
        bus.vji_tdo <= held;
        held        <= bus.vji_tdi;
        sdr_rises   <= sdr_rises + 1;
      end
      if (bus.vji_udr) begin
        udr_rises <= udr_rises + 1;
        udr_q.push_back(sdr_rises);
        sdr_rises <= 0;
      end
    end
    tck_prev <= bus.vji_tck;
    if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_dr);
  end

  // waits in IDLE for cmd_ready, returns once the accepting edge has passed
  task automatic accept_cmd(input logic [1:0] ir, input logic [37:0] dr);
    int n;
    bus.cmd_ir    = ir;
    bus.cmd_dr    = dr;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
    end
    if (n >= 3000) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.rsp_valid) break;
    end
    if (lat >= 3000) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_rsp_ready();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int n;
    logic [37:0] snap;
    logic [37:0] b2b_dr[3];
    logic [37:0] b2b_exp[3];

    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_ir     = 2'b00;
    bus.cmd_dr     = '0;
    bus.rsp_ready  = 1'b0;
    bus.vji_tdo    = 1'b0;
    bus.vji_ir_out = 2'b00;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_tck", 64'(bus.vji_tck), 64'd0);
    chk("rst_tdi", 64'(bus.vji_tdi), 64'd0);
    chk("rst_ir_in", 64'(bus.vji_ir_in), 64'd0);
    chk("rst_strobes", 64'({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}), 64'b00001);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_dr", 64'(bus.rsp_dr), 64'd0);
    chk("rst_rsp_ir_out", 64'(bus.rsp_ir_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // rsp_ready with nothing pending changes nothing
    pulse_rsp_ready();
    chk("idle_rsp_ready_valid", 64'(bus.rsp_valid), 64'd0);
    chk("idle_rsp_ready_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // loopback, ir_out capture, latency
    first_tdo      = 1'b1;
    bus.vji_ir_out = 2'b10;
    accept_cmd(IR_TRACE, 38'h2A_5A5A_A5A5);
    bus.cmd_valid = 1'b0;
    chk("a_busy", 64'(bus.busy), 64'd1);
    chk("a_ir_in_mid", 64'(bus.vji_ir_in), 64'h1);
    wait_rsp(lat);
    chk("a_latency_in_window", 64'((lat >= 359) && (lat <= 361)), 64'd1);
    chk("a_rsp_dr", 64'(bus.rsp_dr), 64'h14_B4B5_4B4B);
    chk("a_rsp_ir_out", 64'(bus.rsp_ir_out), 64'h2);
    chk("a_sdr_rises", 64'(udr_q.size() > 0 ? udr_q[0] : -1), 64'd38);
    chk("a_udr_rises", 64'(udr_rises), 64'd1);

    // backpressure: everything holds while rsp_ready is low
    snap = bus.rsp_dr;
    bad  = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_dr !== snap || bus.vji_tck || bus.cmd_ready) bad++;
    end
    chk("bp_hold_violations", 64'(bad), 64'd0);
    pulse_rsp_ready();
    chk("bp_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
    chk("bp_rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
    chk("bp_busy_after", 64'(bus.busy), 64'd0);
    chk("bp_ir_in_held", 64'(bus.vji_ir_in), 64'h1);

    // reset in the middle of SDR
    accept_cmd(IR_OCIMEM, 38'h15_5555_5555);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (sdr_rises < 20 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("r_reach_bit20", 64'(n < 3000), 64'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("r_tck", 64'(bus.vji_tck), 64'd0);
    chk("r_strobes", 64'({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}), 64'b00001);
    chk("r_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("r_rsp_dr_cleared", 64'(bus.rsp_dr), 64'd0);
    chk("r_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("r_no_udr", 64'(udr_rises), 64'd0);
    chk("r_no_rsp", 64'(rsp_q.size()), 64'd1);

    // a clean command after the aborted one
    first_tdo      = 1'b0;
    bus.vji_ir_out = 2'b01;
    accept_cmd(IR_BREAK, 38'h3F_0000_FFFF);
    bus.cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("r2_rsp_dr", 64'(bus.rsp_dr), 64'h3E_0001_FFFE);
    chk("r2_rsp_ir_out", 64'(bus.rsp_ir_out), 64'h1);
    chk("r2_ir_in", 64'(bus.vji_ir_in), 64'h2);
    pulse_rsp_ready();

    // back-to-back with valid and ready held high
    first_tdo     = 1'b1;
    b2b_dr[0]     = 38'h00_0000_0000;  b2b_exp[0] = 38'h00_0000_0001;
    b2b_dr[1]     = 38'h3F_FFFF_FFFF;  b2b_exp[1] = 38'h3F_FFFF_FFFF;
    b2b_dr[2]     = 38'h12_3456_789A;  b2b_exp[2] = 38'h24_68AC_F135;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) accept_cmd(IR_TRACECTRL, b2b_dr[i]);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (rsp_q.size() < 5 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("b2b_rsp_count", 64'(rsp_q.size()), 64'd5);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_rsp_dr%0d", i), 64'(rsp_q.size() == 5 ? rsp_q[2+i] : '1), 64'(b2b_exp[i]));
    chk("udr_count", 64'(udr_q.size()), 64'd5);
    for (int i = 0; i < udr_q.size(); i++)
      chk($sformatf("sdr_before_udr%0d", i), 64'(udr_q[i]), 64'd38);
    chk("strobe_onehot_violations", 64'(onehot_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
